fdsu_seq_ctrl: RTL and testbench
================================

# fdsu_seq_ctrl

Sequencer for the iterative FPU divide/square-root datapath. It accepts one EX1 issue at a time and retires special-case operands (NaN/Inf/zero) in EX1. Normal operands run through a fixed number of datapath iterations and one rounding cycle. The result is then held on the float-register write-back bus until granted. The block also stalls further issue while busy and handles pipeline flush.

## Interface
Parameters:
- `DIV_ITERS`, default 13: datapath iterations for divide, must be ≥1.
- `SQRT_ITERS`, default 13: datapath iterations for square root, must be ≥1.
- `CNT_W`, default 5: iteration counter width, must satisfy 2^CNT_W > max iterations.

Ports:
- `forever_cpuclk` in 1: clock. All state changes on its rising edge.
- `cpurst_b` in 1: reset, asynchronous, active-low.
- `ex1_sel` in 1: an EX1 instruction targets this unit.
- `ex1_pipe_stall` in 1: EX1 is stalled by someone else. No issue is accepted.
- `ex1_op_sqrt` in 1: 1 means sqrt, 0 means divide.
- `ex1_special` in 1: operands are special-case. The operation completes in EX1.
- `ex1_dst_freg` in 5: destination float register.
- `flush` in 1: pipeline flush.
- `dp_result` in 32: rounded result from the datapath, valid during RND.
- `dp_fflags` in 5: exception flags from the datapath, valid during RND.
- `frbus_wb_grant` in 1: write-back bus grant.
- `ex1_stall` out 1: stalls EX1 while the unit is busy.
- `ex1_cmplt` out 1: special-case completion pulse.
- `dp_load` out 1: load operands into the datapath.
- `dp_iter_en` out 1: datapath iteration enable.
- `dp_round_en` out 1: datapath rounding enable.
- `no_op` out 1: unit is idle.
- `frbus_wb_vld` out 1: write-back request.
- `frbus_data` out 32: write-back data.
- `frbus_fflags` out 5: write-back flags.
- `frbus_freg` out 5: write-back destination register.
- `dbg_state` out 2: encoded current state.

## Operation
- States: IDLE=0, ITER=1, RND=2, WB=3.
- Accept condition: `accept` = IDLE & `ex1_sel` & !`ex1_pipe_stall` & !`flush`.
- `accept` with `ex1_special`=1:
  - `ex1_cmplt`=1 combinationally in that cycle.
  - State stays IDLE. No datapath enables are raised.
- `accept` with `ex1_special`=0:
  - `dp_load`=1 combinationally in that cycle.
  - `freg_q` ← `ex1_dst_freg`.
  - `cnt` ← (`ex1_op_sqrt` ? `SQRT_ITERS` : `DIV_ITERS`) − 1.
  - Next state ITER.
- ITER:
  - `dp_iter_en`=1.
  - If `cnt`==0, go to RND; otherwise `cnt` ← `cnt`−1.
- RND:
  - `dp_round_en`=1.
  - On exit, capture `dp_result`/`dp_fflags` into the write-back registers. Next state WB.
- WB:
  - `frbus_wb_vld`=1. `frbus_data`, `frbus_fflags` and `frbus_freg` are held stable.
  - `frbus_wb_grant`=1 → IDLE next cycle.
  - A new `accept` is not possible until IDLE.
- `ex1_stall` = `ex1_sel` & (state ≠ IDLE).
- `no_op` = (state == IDLE).
- Outputs `frbus_data`, `frbus_fflags` and `frbus_freg` are registered. Between operations they hold their last value.
- Flush:
  - In ITER or RND: next state IDLE, no write-back, registers not updated.
  - In IDLE: suppresses `accept`, including `ex1_cmplt`.
  - In WB: ignored, because the result is already committed.
- Grant seen outside WB: ignored.

## Timing
- Reset values: state IDLE, `cnt`=0, write-back registers 0, `no_op`=1. Every other output is 0.
- Reset asserted mid-operation aborts immediately. The unit returns to IDLE with no write-back.
- Normal latency, with accept in cycle 0:
  - Cycles 1..N: ITER, where N = iteration count.
  - Cycle N+1: RND.
  - First `frbus_wb_vld` in cycle N+2.
  - IDLE the cycle after the grant.
  - Minimum issue-to-issue spacing is N+3 cycles.
- `ex1_cmplt`, `dp_load` and `ex1_stall` are combinational from the current inputs and state.
- All other outputs are decoded from registered state.
- Counter boundary: with an iteration count of 1, ITER lasts exactly one cycle.

## Structure
- Package `fdsu_seq_pkg` holds:
  - `fdsu_state_e` (2-bit enum: IDLE/ITER/RND/WB).
  - Default iteration constants `FDSU_DIV_ITERS`=13 and `FDSU_SQRT_ITERS`=13.
- Single flat module; no sub-module. The counter and FSM are small enough to stay inline.

## Test plan
- Reset with inputs idle → `no_op`=1, `frbus_wb_vld`=0, `dbg_state`=0. All other outputs are 0.
- Divide issue, `ex1_dst_freg`=5'd7, `dp_result`=32'h3F800000 during RND, grant held at 1:
  - `dp_iter_en` high for exactly 13 cycles, then `dp_round_en` for 1 cycle.
  - `frbus_wb_vld` in cycle 15 with data 32'h3F800000 and freg 7.
  - Back to IDLE in cycle 16.
- Special-case issue (`ex1_special`=1) → `ex1_cmplt` pulses for 1 cycle. State stays IDLE and `dp_load`=0.
- Busy and grant behaviour:
  - Second `ex1_sel` while in ITER → `ex1_stall`=1 until IDLE.
  - Grant withheld for 5 cycles in WB → `frbus_wb_vld` and data stay stable. IDLE one cycle after the grant.
- Flush in ITER cycle 4 → IDLE next cycle, no `frbus_wb_vld`. Flush in WB → write-back still completes.
- Parameter check, SQRT_ITERS=1 with a sqrt issue → exactly 1 ITER cycle. Reset asserted in RND → IDLE immediately, no write-back.

Source files
------------

// File: rtl/fdsu_seq_pkg.sv
// Shared types and default constants for the FPU divide/sqrt sequencer.
//   fdsu_state_e    : sequencer state encoding (IDLE/ITER/RND/WB)
//   FDSU_DIV_ITERS  : default datapath iteration count for divide
//   FDSU_SQRT_ITERS : default datapath iteration count for square root
package fdsu_seq_pkg;

    typedef enum logic [1:0] {
        FDSU_IDLE = 2'd0,
        FDSU_ITER = 2'd1,
        FDSU_RND  = 2'd2,
        FDSU_WB   = 2'd3
    } fdsu_state_e;

    localparam int FDSU_DIV_ITERS  = 13;
    localparam int FDSU_SQRT_ITERS = 13;

endpackage

// File: rtl/fdsu_seq_ctrl.sv
// Sequencer for the iterative FPU divide/square-root datapath.
// Accepts one EX1 issue at a time. Special-case operands retire in EX1.
// Normal operands run through DIV_ITERS/SQRT_ITERS datapath iterations and one
// rounding cycle. The result is then held on the write-back bus until granted.
//
// Ports:
//   forever_cpuclk          clock (rising edge)
//   cpurst_b                asynchronous active-low reset
//   ex1_sel/ex1_pipe_stall  EX1 issue request / external EX1 stall
//   ex1_op_sqrt             1 = sqrt, 0 = divide
//   ex1_special             operands are special-case, complete in EX1
//   ex1_dst_freg            destination float register
//   flush                   pipeline flush
//   dp_result/dp_fflags     datapath rounded result and flags, valid in RND
//   frbus_wb_grant          write-back bus grant
//   ex1_stall               EX1 stall while the unit is busy
//   ex1_cmplt               special-case completion pulse
//   dp_load/dp_iter_en/dp_round_en  datapath controls
//   no_op                   unit idle
//   frbus_wb_vld/data/fflags/freg   write-back bus
//   dbg_state               encoded current state
module fdsu_seq_ctrl
    import fdsu_seq_pkg::*;
#(
    parameter int DIV_ITERS  = FDSU_DIV_ITERS,
    parameter int SQRT_ITERS = FDSU_SQRT_ITERS,
    parameter int CNT_W      = 5
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        ex1_sel,
    input  logic        ex1_pipe_stall,
    input  logic        ex1_op_sqrt,
    input  logic        ex1_special,
    input  logic [4:0]  ex1_dst_freg,
    input  logic        flush,
    input  logic [31:0] dp_result,
    input  logic [4:0]  dp_fflags,
    input  logic        frbus_wb_grant,
    output logic        ex1_stall,
    output logic        ex1_cmplt,
    output logic        dp_load,
    output logic        dp_iter_en,
    output logic        dp_round_en,
    output logic        no_op,
    output logic        frbus_wb_vld,
    output logic [31:0] frbus_data,
    output logic [4:0]  frbus_fflags,
    output logic [4:0]  frbus_freg,
    output logic [1:0]  dbg_state
);

    // The counter is loaded with (iterations - 1) and ITER exits when it hits
    // zero, so an iteration count of 1 gives exactly one ITER cycle.
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_ITERS - 1);
    localparam logic [CNT_W-1:0] SQRT_LAST = CNT_W'(SQRT_ITERS - 1);

    fdsu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       freg_q, freg_d;
    logic [31:0]      data_q, data_d;
    logic [4:0]       fflags_q, fflags_d;
    logic             accept;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        freg_d   = freg_q;
        data_d   = data_q;
        fflags_d = fflags_q;

        accept   = (state_q == FDSU_IDLE) && ex1_sel && !ex1_pipe_stall && !flush;

        case (state_q)
            FDSU_IDLE: begin
                if (accept && !ex1_special) begin
                    state_d = FDSU_ITER;
                    freg_d  = ex1_dst_freg;
                    cnt_d   = ex1_op_sqrt ? SQRT_LAST : DIV_LAST;
                end
            end
            FDSU_ITER: begin
                // Flush abandons the operation; nothing is written back.
                if (flush) begin
                    state_d = FDSU_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = FDSU_RND;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FDSU_RND: begin
                if (flush) begin
                    state_d = FDSU_IDLE;
                end else begin
                    state_d  = FDSU_WB;
                    data_d   = dp_result;
                    fflags_d = dp_fflags;
                end
            end
            FDSU_WB: begin
                // The result is committed here, so flush has no effect.
                if (frbus_wb_grant) begin
                    state_d = FDSU_IDLE;
                end
            end
            default: state_d = FDSU_IDLE;
        endcase
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q  <= FDSU_IDLE;
            cnt_q    <= '0;
            freg_q   <= '0;
            data_q   <= '0;
            fflags_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            freg_q   <= freg_d;
            data_q   <= data_d;
            fflags_q <= fflags_d;
        end
    end

    assign ex1_cmplt    = accept && ex1_special;
    assign dp_load      = accept && !ex1_special;
    assign ex1_stall    = ex1_sel && (state_q != FDSU_IDLE);
    assign no_op        = (state_q == FDSU_IDLE);
    assign dp_iter_en   = (state_q == FDSU_ITER);
    assign dp_round_en  = (state_q == FDSU_RND);
    assign frbus_wb_vld = (state_q == FDSU_WB);
    assign frbus_data   = data_q;
    assign frbus_fflags = fflags_q;
    assign frbus_freg   = freg_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_fdsu_seq_ctrl.sv
module tb_fdsu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0, pstall = 1'b0, op_sqrt = 1'b0, special = 1'b0;
    logic [4:0]  dst = '0;
    logic        flush = 1'b0;
    logic [31:0] dp_result = '0;
    logic [4:0]  dp_fflags = '0;
    logic        grant = 1'b0;

    logic        ex1_stall, ex1_cmplt, dp_load, dp_iter_en, dp_round_en, no_op;
    logic        frbus_wb_vld;
    logic [31:0] frbus_data;
    logic [4:0]  frbus_fflags, frbus_freg;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    localparam int N_DIV  = 13;
    localparam int N_SQRT = 1;

    fdsu_seq_ctrl #(.DIV_ITERS(N_DIV), .SQRT_ITERS(N_SQRT), .CNT_W(5)) dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_n),
        .ex1_sel        (sel),
        .ex1_pipe_stall (pstall),
        .ex1_op_sqrt    (op_sqrt),
        .ex1_special    (special),
        .ex1_dst_freg   (dst),
        .flush          (flush),
        .dp_result      (dp_result),
        .dp_fflags      (dp_fflags),
        .frbus_wb_grant (grant),
        .ex1_stall      (ex1_stall),
        .ex1_cmplt      (ex1_cmplt),
        .dp_load        (dp_load),
        .dp_iter_en     (dp_iter_en),
        .dp_round_en    (dp_round_en),
        .no_op          (no_op),
        .frbus_wb_vld   (frbus_wb_vld),
        .frbus_data     (frbus_data),
        .frbus_fflags   (frbus_fflags),
        .frbus_freg     (frbus_freg),
        .dbg_state      (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: an operation is tracked by its age in cycles since
    // accept. Ages 1..n are iterations, n+1 is rounding, n+2 onward is
    // write-back until granted.
    bit          m_busy;
    int          m_age, m_n;
    logic [31:0] m_data;
    logic [4:0]  m_flags, m_freg;

    function automatic int m_phase(); // 0 idle, 1 iter, 2 round, 3 write-back
        if (!m_busy)            return 0;
        if (m_age <= m_n)       return 1;
        if (m_age == m_n + 1)   return 2;
        return 3;
    endfunction

    function automatic bit m_accept();
        return (m_phase() == 0) && sel && !pstall && !flush;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_age   <= 0;
            m_n     <= 0;
            m_data  <= '0;
            m_flags <= '0;
            m_freg  <= '0;
        end else begin
            case (m_phase())
                0: if (m_accept() && !special) begin
                    m_busy <= 1'b1;
                    m_age  <= 1;
                    m_n    <= op_sqrt ? N_SQRT : N_DIV;
                    m_freg <= dst;
                end
                1: if (flush) m_busy <= 1'b0; else m_age <= m_age + 1;
                2: if (flush) m_busy <= 1'b0;
                   else begin
                       m_age   <= m_age + 1;
                       m_data  <= dp_result;
                       m_flags <= dp_fflags;
                   end
                default: if (grant) m_busy <= 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            int ph;
            ph = m_phase();
            chk("cmplt",   {31'd0, ex1_cmplt},    {31'd0, m_accept() && special});
            chk("load",    {31'd0, dp_load},      {31'd0, m_accept() && !special});
            chk("stall",   {31'd0, ex1_stall},    {31'd0, sel && (ph != 0)});
            chk("no_op",   {31'd0, no_op},        {31'd0, ph == 0});
            chk("iter_en", {31'd0, dp_iter_en},   {31'd0, ph == 1});
            chk("rnd_en",  {31'd0, dp_round_en},  {31'd0, ph == 2});
            chk("wb_vld",  {31'd0, frbus_wb_vld}, {31'd0, ph == 3});
            chk("state",   {30'd0, dbg_state},    ph);
            chk("data",    frbus_data,            m_data);
            chk("fflags",  {27'd0, frbus_fflags}, {27'd0, m_flags});
            chk("freg",    {27'd0, frbus_freg},   {27'd0, m_freg});
        end
    end

    // Present one issue in the next cycle (cycle 0) and return in cycle 1.
    task automatic issue(input logic sq, input logic sp, input logic [4:0] d);
        @(posedge clk); #1;
        sel = 1'b1; op_sqrt = sq; special = sp; dst = d;
        @(posedge clk); #1;
        sel = 1'b0; special = 1'b0;
    endtask

    // Wait at negedges until the condition signal selected by 'which' is high.
    task automatic wait_for(input int which, input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which == 0 && no_op) || (which == 1 && dp_round_en) ||
                (which == 2 && frbus_wb_vld)) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_timeout"}, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        int iters, rnds, first_wb, idle_at;
        logic [31:0] held;

        // Reset
        repeat (2) @(negedge clk);
        chk("rst_no_op",  {31'd0, no_op},        32'd1);
        chk("rst_wb_vld", {31'd0, frbus_wb_vld}, 32'd0);
        chk("rst_state",  {30'd0, dbg_state},    32'd0);
        chk("rst_data",   frbus_data,            32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        check_en = 1'b1;

        // Divide, grant held high
        grant = 1'b1; dp_result = 32'h3F80_0000; dp_fflags = 5'h01;
        issue(1'b0, 1'b0, 5'd7);
        iters = 0; rnds = 0; first_wb = 0; idle_at = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (dp_iter_en)  iters++;
            if (dp_round_en) rnds++;
            if (frbus_wb_vld && first_wb == 0) begin
                first_wb = k;
                chk("div_data", frbus_data, 32'h3F80_0000);
                chk("div_freg", {27'd0, frbus_freg}, 32'd7);
            end
            if (no_op) begin idle_at = k; break; end
        end
        chk("div_iters", iters, 32'd13);
        chk("div_rnds", rnds, 32'd1);
        chk("div_first_wb", first_wb, 32'd15);
        chk("div_idle", idle_at, 32'd16);

        // Special-case issue
        @(posedge clk); #1;
        sel = 1'b1; special = 1'b1; dst = 5'd3;
        @(negedge clk);
        chk("sp_cmplt", {31'd0, ex1_cmplt}, 32'd1);
        chk("sp_load",  {31'd0, dp_load},   32'd0);
        @(posedge clk); #1;
        sel = 1'b0; special = 1'b0;
        @(negedge clk);
        chk("sp_idle",  {31'd0, no_op},     32'd1);
        chk("sp_pulse", {31'd0, ex1_cmplt}, 32'd0);

        // Flush in IDLE suppresses the special completion
        @(posedge clk); #1;
        sel = 1'b1; special = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("idle_flush_cmplt", {31'd0, ex1_cmplt}, 32'd0);
        @(posedge clk); #1;
        sel = 1'b0; special = 1'b0; flush = 1'b0;

        // Busy stall, grant withheld for 5 cycles
        grant = 1'b0; dp_result = 32'hC0A0_1234; dp_fflags = 5'h12;
        issue(1'b0, 1'b0, 5'd21);
        sel = 1'b1;
        @(negedge clk);
        chk("busy_stall", {31'd0, ex1_stall}, 32'd1);
        repeat (3) @(posedge clk);
        #1 sel = 1'b0;
        wait_for(2, 30, "wb_wait");
        dp_result = 32'hFFFF_FFFF;
        held = frbus_data;
        repeat (5) begin
            @(negedge clk);
            chk("hold_vld",  {31'd0, frbus_wb_vld}, 32'd1);
            chk("hold_data", frbus_data, held);
        end
        chk("hold_lit", frbus_data, 32'hC0A0_1234);
        @(posedge clk); #1 grant = 1'b1;
        @(posedge clk); #1 grant = 1'b0;
        @(negedge clk);
        chk("grant_idle", {31'd0, no_op}, 32'd1);

        // Flush in ITER cycle 4
        issue(1'b0, 1'b0, 5'd9);
        repeat (3) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_iter_idle", {31'd0, no_op}, 32'd1);
        repeat (20) @(negedge clk);
        chk("flush_no_wb", frbus_data, 32'hC0A0_1234);

        // Flush in WB is ignored
        dp_result = 32'h4049_0FDB; dp_fflags = 5'h04;
        issue(1'b0, 1'b0, 5'd30);
        wait_for(2, 30, "wbf_wait");
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        chk("wb_flush_vld", {31'd0, frbus_wb_vld}, 32'd1);
        @(posedge clk); #1 flush = 1'b0; grant = 1'b1;
        @(posedge clk); #1 grant = 1'b0;
        @(negedge clk);
        chk("wb_flush_data", frbus_data, 32'h4049_0FDB);
        chk("wb_flush_idle", {31'd0, no_op}, 32'd1);

        // Sqrt with a single iteration
        grant = 1'b1; dp_result = 32'h3FB5_04F3; dp_fflags = 5'h01;
        issue(1'b1, 1'b0, 5'd2);
        iters = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (dp_iter_en) iters++;
            if (no_op) break;
        end
        chk("sqrt_iters", iters, 32'd1);
        chk("sqrt_data", frbus_data, 32'h3FB5_04F3);

        // Reset during RND
        grant = 1'b0; dp_result = 32'h1111_2222;
        issue(1'b0, 1'b0, 5'd15);
        wait_for(1, 30, "rnd_wait");
        #2 rst_n = 1'b0;
        #1;
        chk("rstrnd_no_op", {31'd0, no_op}, 32'd1);
        chk("rstrnd_vld",   {31'd0, frbus_wb_vld}, 32'd0);
        chk("rstrnd_data",  frbus_data, 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rstrnd_no_wb", {31'd0, frbus_wb_vld}, 32'd0);

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
